// File: rtl/spi_cmd_rx.sv
// ============================================================================
// spi_cmd_rx
// ----------------------------------------------------------------------------
// SPI mode-0 slave that receives one-byte movement commands and hands each
// byte to the player-position updater as spi_data with a stretched spi_flag
// pulse. The pulse is long enough for the updater's two-flop synchroniser and
// rising-edge detector. The block also owns the 9-bit player_angle register
// (index into the 512-entry trig LUT) and updates it on turn commands
// (0x03 left, 0x04 right).
//
// Optional feature macro: SPI_CMD_RX_ECHO_EN
//   defined     : miso shifts out the previously delivered byte, MSB first,
//                 MSB presented at synced cs_n fall, next bit on each synced
//                 sclk fall.
//   not defined : miso tied to 0, no echo shift register.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   sclk         in   SPI clock (asynchronous to clk, clk >= 8x sclk)
//   mosi         in   SPI data in, MSB first
//   cs_n         in   SPI chip select, active low
//   miso         out  SPI data out (echo of last delivered byte, or 0)
//   spi_flag     out  high for FLAG_HOLD cycles per delivered byte
//   spi_data     out  last delivered byte, stable until the next pop
//   player_angle out  current heading, mod 512
//   frame_err    out  one-cycle pulse when a partial byte is discarded
//   overrun      out  one-cycle pulse when a completed byte is dropped
// ============================================================================
module spi_cmd_rx #(
    parameter int         TURN_STEP  = 4,
    parameter int         FLAG_HOLD  = 4,
    parameter int         FLAG_GAP   = 2,
    parameter logic [8:0] ANGLE_INIT = 9'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs_n,
    output logic       miso,
    output logic       spi_flag,
    output logic [7:0] spi_data,
    output logic [8:0] player_angle,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_MAX = (FLAG_HOLD > FLAG_GAP) ? FLAG_HOLD : FLAG_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Synchroniser chains: _p0 first flop, _p1 synchronised, _p2 edge history
    logic             sclk_p0, sclk_p1, sclk_p2;
    logic             mosi_p0, mosi_p1;
    logic             cs_p0, cs_p1, cs_p2;

    logic             armed;
    logic [2:0]       bit_cnt;
    logic [6:0]       shift_reg;

    logic [7:0]       buf_data;
    logic             buf_full;
    state_t           state;
    logic [CNT_W-1:0] phase_cnt;

    logic             sclk_rise;
    logic             cs_rise;
    logic             rx_en;
    logic             byte_done;
    logic             pop;
    logic [7:0]       rx_byte;

    // Heading update for a delivered command; 9-bit arithmetic wraps mod 512.
    function automatic logic [8:0] turn_angle(input logic [8:0] angle,
                                              input logic [7:0] cmd);
        case (cmd)
            8'h03:   turn_angle = angle - 9'(TURN_STEP);
            8'h04:   turn_angle = angle + 9'(TURN_STEP);
            default: turn_angle = angle;
        endcase
    endfunction

    // ---- stage p0/p1/p2: input synchronisers and edge history ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
            cs_p0   <= 1'b0;
            cs_p1   <= 1'b0;
            cs_p2   <= 1'b0;
        end else begin
            sclk_p0 <= sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
            cs_p0   <= cs_n;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
        end
    end

    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign cs_rise   = cs_p1 & ~cs_p2;
    // The synchroniser resets to "selected"; reception waits until chip
    // select has been seen high so a frame cut by reset is never resumed.
    assign rx_en     = armed & ~cs_p1;
    assign byte_done = rx_en & sclk_rise & (bit_cnt == 3'd7);
    assign rx_byte   = {shift_reg, mosi_p1};
    assign pop       = (state == IDLE) & buf_full;

    // ---- receive shifter and frame-error detection ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed     <= 1'b0;
            bit_cnt   <= 3'd0;
            shift_reg <= 7'd0;
            frame_err <= 1'b0;
        end else begin
            armed     <= armed | cs_p1;
            frame_err <= cs_rise & (bit_cnt != 3'd0);
            if (cs_p1) begin
                bit_cnt <= 3'd0;
            end else if (rx_en && sclk_rise) begin
                shift_reg <= {shift_reg[5:0], mosi_p1};
                bit_cnt   <= bit_cnt + 3'd1;
            end
        end
    end

    // ---- pending buffer, output FSM and heading register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_data     <= 8'h00;
            buf_full     <= 1'b0;
            overrun      <= 1'b0;
            state        <= IDLE;
            phase_cnt    <= '0;
            spi_flag     <= 1'b0;
            spi_data     <= 8'h00;
            player_angle <= ANGLE_INIT;
        end else begin
            overrun <= 1'b0;
            // A pop in the same cycle frees the slot for the new byte.
            if (byte_done) begin
                if (buf_full && !pop) begin
                    overrun <= 1'b1;
                end else begin
                    buf_data <= rx_byte;
                    buf_full <= 1'b1;
                end
            end else if (pop) begin
                buf_full <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (buf_full) begin
                        spi_data     <= buf_data;
                        player_angle <= turn_angle(player_angle, buf_data);
                        spi_flag     <= 1'b1;
                        phase_cnt    <= '0;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (phase_cnt == CNT_W'(FLAG_HOLD - 1)) begin
                        spi_flag  <= 1'b0;
                        phase_cnt <= '0;
                        state     <= GAP;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    // The IDLE cycle that follows is the last low cycle, so
                    // the low time between back-to-back pulses is FLAG_GAP.
                    if (phase_cnt == CNT_W'(FLAG_GAP - 2)) begin
                        phase_cnt <= '0;
                        state     <= IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SPI_CMD_RX_ECHO_EN
    logic       sclk_fall;
    logic       cs_fall;
    logic [6:0] echo_sr;

    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign cs_fall   = ~cs_p1 & cs_p2;

    // ---- echo shifter: MSB at frame start, next bit per sclk fall ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            echo_sr <= 7'd0;
            miso    <= 1'b0;
        end else if (cs_fall) begin
            echo_sr <= spi_data[6:0];
            miso    <= spi_data[7];
        end else if (!cs_p1 && sclk_fall) begin
            echo_sr <= {echo_sr[5:0], 1'b0};
            miso    <= echo_sr[6];
        end
    end
`else
    assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_rx.sv
`timescale 1ns/1ps
module tb_spi_cmd_rx;

    localparam int         FLAG_HOLD = 4;
    localparam int         FLAG_GAP  = 2;
    localparam int         TURN_STEP = 4;
    localparam int         S_HOLD    = 100;
    localparam int         S_GAP     = 60;
    localparam logic [8:0] S_INIT    = 9'h1FE;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       sclk     = 1'b0;
    logic       mosi     = 1'b0;
    logic       cs_n     = 1'b1;
    logic       slow_sel = 1'b0;
    logic       cs_n_slow;

    logic       miso, spi_flag, frame_err, overrun;
    logic [7:0] spi_data;
    logic [8:0] player_angle;
    logic       s_miso, s_flag, s_frame_err, s_overrun;
    logic [7:0] s_data;
    logic [8:0] s_angle;

    assign cs_n_slow = cs_n | ~slow_sel;

    always #5 clk = ~clk;

    spi_cmd_rx dut (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .miso(miso), .spi_flag(spi_flag), .spi_data(spi_data),
        .player_angle(player_angle), .frame_err(frame_err), .overrun(overrun)
    );

    // Second instance with a long flag period so a byte can be dropped
    spi_cmd_rx #(
        .TURN_STEP(TURN_STEP), .FLAG_HOLD(S_HOLD), .FLAG_GAP(S_GAP), .ANGLE_INIT(S_INIT)
    ) dut_slow (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs_n(cs_n_slow),
        .miso(s_miso), .spi_flag(s_flag), .spi_data(s_data),
        .player_angle(s_angle), .frame_err(s_frame_err), .overrun(s_overrun)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [8:0] angle;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       exp_s[$];
    logic [7:0] tx_q[$];

    int checks = 0;
    int errors = 0;
    int ang_m  = 0;
    int fe_exp = 0;
    int fe_seen = 0, ov_seen = 0, sfe_seen = 0, sov_seen = 0;
`ifdef SPI_CMD_RX_ECHO_EN
    logic [7:0] last_m = 8'h00;
    logic [7:0] echo_cap = 8'h00;
`endif

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference heading: plain modular arithmetic on the command code
    function automatic int model_turn(input int a, input logic [7:0] b, input int step);
        if (b == 8'h03) return (a - step + 512) % 512;
        if (b == 8'h04) return (a + step) % 512;
        return a;
    endfunction

    function automatic exp_t mk(input logic [7:0] d, input int a);
        exp_t e;
        e.data  = d;
        e.angle = 9'(a);
        return e;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b, input int half);
        mosi = b;
        wait_clk(half);
`ifdef SPI_CMD_RX_ECHO_EN
        echo_cap = {echo_cap[6:0], miso};
`else
        check("miso_zero", int'(miso), 0);
`endif
        sclk = 1'b1;
        wait_clk(half);
        sclk = 1'b0;
    endtask

    // Sends tx_q as one frame, then 'partial' extra bits before cs_n rises.
    task automatic send_frame(input int half, input int partial);
        logic [7:0] b;
`ifdef SPI_CMD_RX_ECHO_EN
        logic [7:0] echo_exp;
        echo_exp = last_m;
`endif
        cs_n = 1'b0;
        wait_clk(half);
        for (int i = 0; i < tx_q.size(); i++) begin
            b = tx_q[i];
            ang_m = model_turn(ang_m, b, TURN_STEP);
            exp_q.push_back(mk(b, ang_m));
`ifdef SPI_CMD_RX_ECHO_EN
            last_m = b;
`endif
            for (int k = 7; k >= 0; k--) spi_bit(b[k], half);
`ifdef SPI_CMD_RX_ECHO_EN
            if (i == 0) check("echo_byte", int'(echo_cap), int'(echo_exp));
`endif
        end
        for (int k = 0; k < partial; k++) spi_bit(1'($urandom_range(0, 1)), half);
        if (partial > 0) fe_exp++;
        wait_clk(half);
        cs_n = 1'b1;
        wait_clk(half + 4);
        tx_q.delete();
    endtask

    task automatic wait_drain(input int extra);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || exp_s.size() != 0) && t < 3000) begin
            wait_clk(1);
            t++;
        end
        check("drain_pending", exp_q.size() + exp_s.size(), 0);
        wait_clk(extra);
    endtask

    // ---- monitor: main instance ----
    logic m_prev = 1'b0;
    int   m_hold = 0, m_low = 1000;
    logic [7:0] m_held = 8'h00;
    logic fe_prev = 1'b0, ov_prev = 1'b0;
    int   fe_len = 0, ov_len = 0;
    exp_t me;

    always @(negedge clk) begin
        if (!reset) begin
            m_prev = 1'b0; m_hold = 0; m_low = 1000;
            fe_prev = 1'b0; ov_prev = 1'b0; fe_len = 0; ov_len = 0;
        end else begin
            if (spi_flag && !m_prev) begin
                if (m_low < 1000) check("flag_gap_ge", int'(m_low >= FLAG_GAP), 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_flag", int'(spi_data), -1);
                end else begin
                    me = exp_q.pop_front();
                    check("spi_data", int'(spi_data), int'(me.data));
                    check("player_angle", int'(player_angle), int'(me.angle));
                end
                m_hold = 1;
                m_held = spi_data;
            end else if (spi_flag) begin
                m_hold++;
                if (spi_data != m_held) check("data_stable", int'(spi_data), int'(m_held));
            end else if (m_prev) begin
                check("flag_hold_len", m_hold, FLAG_HOLD);
                m_low = 1;
            end else if (m_low < 1000) begin
                m_low++;
            end
            m_prev = spi_flag;

            if (frame_err) begin
                if (!fe_prev) fe_seen++;
                fe_len++;
            end else if (fe_prev) begin
                check("frame_err_width", fe_len, 1);
                fe_len = 0;
            end
            fe_prev = frame_err;
            if (overrun) begin
                if (!ov_prev) ov_seen++;
                ov_len++;
            end else if (ov_prev) begin
                ov_len = 0;
            end
            ov_prev = overrun;
        end
    end

    // ---- monitor: slow instance ----
    logic s_prev = 1'b0, sov_prev = 1'b0, sfe_prev = 1'b0;
    int   s_hold = 0, s_low = 1000, sov_len = 0;
    exp_t se;

    always @(negedge clk) begin
        if (!reset) begin
            s_prev = 1'b0; s_hold = 0; s_low = 1000; sov_prev = 1'b0; sfe_prev = 1'b0; sov_len = 0;
        end else begin
            if (s_flag && !s_prev) begin
                if (s_low < 1000) check("slow_gap_ge", int'(s_low >= S_GAP), 1);
                if (exp_s.size() == 0) begin
                    check("slow_unexpected_flag", int'(s_data), -1);
                end else begin
                    se = exp_s.pop_front();
                    check("slow_data", int'(s_data), int'(se.data));
                    check("slow_angle", int'(s_angle), int'(se.angle));
                end
                s_hold = 1;
            end else if (s_flag) begin
                s_hold++;
            end else if (s_prev) begin
                check("slow_hold_len", s_hold, S_HOLD);
                s_low = 1;
            end else if (s_low < 1000) begin
                s_low++;
            end
            s_prev = s_flag;

            if (s_overrun) begin
                if (!sov_prev) sov_seen++;
                sov_len++;
            end else if (sov_prev) begin
                check("overrun_width", sov_len, 1);
                sov_len = 0;
            end
            sov_prev = s_overrun;
            if (s_frame_err && !sfe_prev) sfe_seen++;
            sfe_prev = s_frame_err;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int   t;
        int   nb, partial, half, sel;
        logic [7:0] b;

        // Reset state
        wait_clk(3);
        check("rst_spi_flag", int'(spi_flag), 0);
        check("rst_spi_data", int'(spi_data), 0);
        check("rst_angle", int'(player_angle), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_miso", int'(miso), 0);
        check("rst_slow_angle", int'(s_angle), int'(S_INIT));
        reset = 1'b1;
        wait_clk(6);

        // Single move command
        tx_q.push_back(8'h01);
        send_frame(4, 0);
        wait_drain(FLAG_HOLD + FLAG_GAP + 4);
        check("move_data_held", int'(spi_data), 8'h01);

        // Turns right then left, wrapping below zero
        for (int i = 0; i < 3; i++) begin
            tx_q.push_back(8'h04);
            send_frame(4, 0);
            wait_drain(FLAG_HOLD + FLAG_GAP + 4);
            check("turn_right_angle", int'(player_angle), 4 * (i + 1));
        end
        for (int i = 0; i < 4; i++) begin
            tx_q.push_back(8'h03);
            send_frame(5, 0);
            wait_drain(FLAG_HOLD + FLAG_GAP + 4);
        end
        check("wrap_below_zero", int'(player_angle), 9'h1FC);

        // Wrap above 511 on the instance starting at 0x1FE
        slow_sel = 1'b1;
        exp_s.push_back(mk(8'h04, 2));
        tx_q.push_back(8'h04);
        send_frame(4, 0);
        wait_drain(S_HOLD + S_GAP + 8);
        check("wrap_above_511", int'(s_angle), 2);

        // Three back-to-back bytes at clk/8: slow instance drops the third
        exp_s.push_back(mk(8'h01, 2));
        exp_s.push_back(mk(8'h02, 2));
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h02);
        tx_q.push_back(8'h01);
        send_frame(4, 0);
        wait_drain(S_HOLD + S_GAP + 8);
        check("overrun_count", sov_seen, 1);
        check("overrun_main_none", ov_seen, 0);
        slow_sel = 1'b0;

        // Partial byte then a full byte
        send_frame(4, 5);
        tx_q.push_back(8'h02);
        send_frame(4, 0);
        wait_drain(FLAG_HOLD + FLAG_GAP + 4);
        check("frame_err_count", fe_seen, fe_exp);
        check("after_partial_data", int'(spi_data), 8'h02);

        // Randomised frames
        for (int it = 0; it < 25; it++) begin
            nb      = $urandom_range(1, 3);
            partial = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
            half    = $urandom_range(4, 7);
            for (int j = 0; j < nb; j++) begin
                sel = $urandom_range(0, 5);
                case (sel)
                    0: b = 8'h01;
                    1: b = 8'h02;
                    2, 3: b = 8'h03;
                    4: b = 8'h04;
                    default: b = 8'($urandom);
                endcase
                if (sel == 4 && $urandom_range(0, 1) == 1) b = 8'h04;
                tx_q.push_back(b);
            end
            send_frame(half, partial);
            wait_drain(FLAG_HOLD + FLAG_GAP + 4);
        end
        check("rand_angle", int'(player_angle), ang_m);
        check("rand_frame_err", fe_seen, fe_exp);

        // Asynchronous reset in the middle of a flag pulse
        exp_q.push_back(mk(8'h01, ang_m));
        cs_n = 1'b0;
        wait_clk(4);
        for (int k = 7; k >= 1; k--) spi_bit(1'(k == 0), 4);
        mosi = 1'b1;
        wait_clk(4);
        sclk = 1'b1;
        t = 0;
        while (!spi_flag && t < 40) begin
            wait_clk(1);
            t++;
        end
        check("flag_before_reset", int'(spi_flag), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_flag", int'(spi_flag), 0);
        check("async_rst_data", int'(spi_data), 0);
        check("async_rst_angle", int'(player_angle), 0);
        sclk = 1'b0;
        cs_n = 1'b1;
        exp_q.delete();
        exp_s.delete();
        ang_m = 0;
`ifdef SPI_CMD_RX_ECHO_EN
        last_m = 8'h00;
`endif
        wait_clk(3);
        reset = 1'b1;
        wait_clk(6);
        tx_q.push_back(8'h04);
        send_frame(4, 0);
        wait_drain(FLAG_HOLD + FLAG_GAP + 4);
        check("post_reset_turn", int'(player_angle), 4);

        check("final_overrun_main", ov_seen, 0);
        check("final_slow_frame_err", sfe_seen, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
